// File: rtl/down_counter_if.sv
// Load/control/status bundle for down_counter.
// The slave modport is the counter side; the master modport is the controller side.
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             io_load_valid;
  logic [WIDTH-1:0] io_load_value;
  logic             io_load_ready;
  logic             io_enable;
  logic             io_clear;
  logic [WIDTH-1:0] io_count;
  logic             io_underflow;
  logic             io_busy;

  modport slave (
    input  io_load_valid, io_load_value, io_enable, io_clear,
    output io_load_ready, io_count, io_underflow, io_busy
  );

  modport master (
    output io_load_valid, io_load_value, io_enable, io_clear,
    input  io_load_ready, io_count, io_underflow, io_busy
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with IDLE/RUN/DONE control and a sticky underflow flag.
// Optional feature: define DOWN_COUNTER_AUTORELOAD_EN to restart from the last loaded value.
module down_counter #(
  parameter int WIDTH = 4
) (
  input logic           clock,
  input logic           reset,
  down_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             underflow;
  logic             load_ready;
  logic             load_accept;
  logic             terminal;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  assign load_ready  = (state != RUN);
  assign load_accept = bus.io_load_valid && load_ready;
  // Loads and terminal count can never coincide: one needs RUN, the other forbids it.
  assign terminal    = (state == RUN) && bus.io_enable && (count == WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      underflow <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else if (load_accept) begin
      count <= bus.io_load_value;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload <= bus.io_load_value;
`endif
      if (bus.io_load_value != '0) begin
        state     <= RUN;
        underflow <= 1'b0;
      end else begin
        state     <= DONE;
        underflow <= 1'b1;
      end
    end else if (terminal) begin
      underflow <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      count     <= reload;
`else
      count     <= '0;
      state     <= DONE;
`endif
    end else begin
      if (state == RUN && bus.io_enable) begin
        count <= count - WIDTH'(1);
      end
      if (bus.io_clear) begin
        underflow <= 1'b0;
      end
    end
  end

  assign bus.io_load_ready = load_ready;
  assign bus.io_count      = count;
  assign bus.io_underflow  = underflow;
  assign bus.io_busy       = (state == RUN);
endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of count and load value.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port io_load_valid  input  1  load request.
REQ-005 SHALL have port io_load_value  input  WIDTH  start value for the countdown.
REQ-006 SHALL have port io_load_ready  output  1  load can be accepted this cycle.
REQ-007 SHALL have port io_enable  input  1  decrement permit while running.
REQ-008 SHALL have port io_clear  input  1  clears the sticky underflow flag.
REQ-009 SHALL have port io_count  output  WIDTH  current count register.
REQ-010 SHALL have port io_underflow  output  1  sticky terminal-count flag.
REQ-011 SHALL have port io_busy  output  1  high while in state RUN.

Function
REQ-012 SHALL implement three states: IDLE, RUN, DONE.
REQ-013 SHALL drive io_load_ready=1 in IDLE and DONE, and io_load_ready=0 in RUN.
REQ-014 SHALL accept a load only when io_load_valid && io_load_ready; on an accept, io_count=io_load_value at the next edge.
REQ-015 SHALL, on accepting a nonzero value, enter RUN and clear io_underflow at the next edge.
REQ-016 SHALL, on accepting value 0, enter DONE with io_count=0 and io_underflow=1 at the next edge.
REQ-017 SHALL, in RUN with io_enable=1, decrement io_count by 1 per cycle, modulo 2^WIDTH, with no wrap below 0 reachable.
REQ-018 SHALL, in RUN with io_enable=0, hold io_count and remain in RUN.
REQ-019 SHALL, in RUN with io_enable=1 and io_count==1, load io_count=0, enter DONE and set io_underflow at the next edge.
REQ-020 SHALL, in IDLE and DONE, hold io_count and ignore io_enable.
REQ-021 SHALL keep io_underflow set until io_clear=1 or a nonzero load is accepted.
REQ-022 SHALL give the set condition priority over io_clear when both occur in the same cycle.
REQ-023 SHALL give the accepted load's effect on io_underflow (REQ-015/016) priority over io_clear when both occur in the same cycle.
REQ-024 SHALL drive io_busy combinationally from state (1 iff RUN).
REQ-025 SHALL drive io_count and io_underflow directly from registers, with no combinational input-to-output path on them.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state=IDLE, io_count=0 and io_underflow=0, so that io_busy=0 and io_load_ready=1.
REQ-027 SHALL give reset priority over load, enable and clear, including mid-countdown in RUN.
REQ-028 SHALL have no reset-dependent output other than those listed in REQ-026.

Configuration
REQ-029 SHALL support the macro DOWN_COUNTER_AUTORELOAD_EN.
REQ-030 SHALL, with the macro defined, store the last accepted load value in a reload register (reset value 0).
REQ-031 SHALL, with the macro defined, at the REQ-019 terminal condition, reload io_count from the reload register, stay in RUN and set io_underflow.
REQ-032 SHALL, with the macro defined, still follow REQ-016 for a load of 0; the counter then stays in DONE.
REQ-033 SHALL, without the macro, implement no reload register and follow REQ-019 exactly.

Verification
REQ-034 SHALL cover reset then load 3 with io_enable held 1 -> io_count 3,2,1,0 on successive cycles; DONE, io_underflow=1, io_busy=0 on the cycle io_count=0.
REQ-035 SHALL cover load 5 with io_enable toggling 1,0,1,0 -> io_count 5,4,4,3,3 and io_busy=1 throughout.
REQ-036 SHALL cover io_load_valid=1 with value 9 during RUN -> io_load_ready=0, the load is ignored and the countdown is unaffected.
REQ-037 SHALL cover load 0 -> next cycle io_count=0, io_underflow=1, state DONE; then io_clear=1 -> io_underflow=0 next cycle.
REQ-038 SHALL cover reset asserted while io_count=2 in RUN -> next cycle io_count=0, io_underflow=0, io_busy=0, io_load_ready=1.
REQ-039 SHALL cover, with DOWN_COUNTER_AUTORELOAD_EN defined, load 2 with io_enable=1 -> io_count 2,1,2,1,2 with io_underflow set from the first reload and io_busy constantly 1.
